// File: rtl/noc_inject_port.sv
// Client-to-router injection port: per-VC FIFOs, round-robin VC arbitration, per-VC credits.
// Latency 2 cycles i_ack->r_v; backpressure via i_ack (target FIFO full) and zero downstream credit.
module noc_inject_port #(
    parameter int D_W     = 32,
    parameter int VC_W    = 3,
    parameter int X_W     = 2,
    parameter int Y_W     = 2,
    parameter int NUM_VC  = 4,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_v,
    input  logic [VC_W-1:0]   i_vc,
    input  logic [X_W-1:0]    i_x,
    input  logic [Y_W-1:0]    i_y,
    input  logic [D_W-1:0]    i_data,
    output logic              i_ack,
    output logic              r_v,
    output logic [VC_W-1:0]   r_vc,
    output logic [X_W-1:0]    r_x,
    output logic [Y_W-1:0]    r_y,
    output logic [D_W-1:0]    r_data,
    input  logic [NUM_VC-1:0] r_credit,
    output logic              err
);
    localparam int IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CRD_W = $clog2(CREDITS + 1);

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] data;
    } flit_t;

    flit_t             mem_q    [NUM_VC][DEPTH];
    logic [CNT_W-1:0]  count_q  [NUM_VC];
    logic [CNT_W-1:0]  count_d  [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
    logic [CRD_W-1:0]  credit_q [NUM_VC];
    logic [CRD_W-1:0]  credit_d [NUM_VC];
    logic [IDX_W-1:0]  rr_ptr_q;

    logic              r_v_q;
    logic [VC_W-1:0]   r_vc_q;
    flit_t             r_flit_q;
    logic              err_q;

    logic              vc_legal, push, ovf;
    logic              push_v, pop_v;
    logic [IDX_W-1:0]  in_idx, cand, gnt_idx;
    logic              gnt_vld;
    flit_t             head;

    always_comb begin
        vc_legal = ({1'b0, i_vc} < (VC_W + 1)'(NUM_VC));
        in_idx   = IDX_W'(i_vc);
        // Push decision uses pre-edge occupancy, so a full FIFO refuses even while popping.
        i_ack    = i_v & ~rst & (~vc_legal | (count_q[in_idx] != CNT_W'(DEPTH)));
        push     = i_ack & vc_legal;

        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_VC; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_VC);
            if (!gnt_vld && count_q[cand] != '0 && credit_q[cand] != '0) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        head = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];

        ovf    = 1'b0;
        push_v = 1'b0;
        pop_v  = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            pop_v       = gnt_vld && (gnt_idx == IDX_W'(v));
            push_v      = push && (in_idx == IDX_W'(v));
            count_d[v]  = count_q[v] + CNT_W'(push_v) - CNT_W'(pop_v);
            wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(push_v);
            rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(pop_v);
            credit_d[v] = credit_q[v];
            // A return coinciding with a grant cancels out and is never an overflow.
            if (r_credit[v] && !pop_v) begin
                if (credit_q[v] == CRD_W'(CREDITS)) ovf = 1'b1;
                else                                credit_d[v] = credit_q[v] + CRD_W'(1);
            end else if (pop_v && !r_credit[v]) begin
                credit_d[v] = credit_q[v] - CRD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[in_idx][wr_ptr_q[in_idx]] <= {i_x, i_y, i_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                count_q[v]  <= '0;
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                credit_q[v] <= CRD_W'(CREDITS);
            end
            rr_ptr_q <= IDX_W'(NUM_VC - 1);
            r_v_q    <= 1'b0;
            r_vc_q   <= '0;
            r_flit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            credit_q <= credit_d;
            r_v_q    <= gnt_vld;
            if (gnt_vld) begin
                rr_ptr_q <= gnt_idx;
                r_vc_q   <= VC_W'(gnt_idx);
                r_flit_q <= head;
            end
            err_q <= err_q | ovf | (i_ack & ~vc_legal);
        end
    end

    assign r_v    = r_v_q;
    assign r_vc   = r_vc_q;
    assign r_x    = r_flit_q.x;
    assign r_y    = r_flit_q.y;
    assign r_data = r_flit_q.data;
    assign err    = err_q;
endmodule

// File: tb/tb_noc_inject_port.sv
// Randomized and directed bench for noc_inject_port against a queue-based reference model.
module tb_noc_inject_port;
    localparam int NUM_VC  = 4;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;

    typedef struct packed {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [31:0] d;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst, i_v, i_ack, r_v, err;
    logic [2:0]  i_vc, r_vc;
    logic [1:0]  i_x, i_y, r_x, r_y;
    logic [31:0] i_data, r_data;
    logic [3:0]  r_credit;

    always #5 clk = ~clk;

    noc_inject_port #(
        .D_W(32), .VC_W(3), .X_W(2), .Y_W(2),
        .NUM_VC(NUM_VC), .DEPTH(DEPTH), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst(rst), .i_v(i_v), .i_vc(i_vc), .i_x(i_x), .i_y(i_y),
        .i_data(i_data), .i_ack(i_ack), .r_v(r_v), .r_vc(r_vc), .r_x(r_x),
        .r_y(r_y), .r_data(r_data), .r_credit(r_credit), .err(err)
    );

    // Reference model state
    flit_t mq [NUM_VC][$];
    int    m_cred [NUM_VC];
    int    m_rr;
    bit    m_rv, m_err, m_init;
    int    m_rvc;
    flit_t m_out;

    int total = 0;
    int bad   = 0;
    int rv_cnt;
    int seq [$];

    logic        obs_ack, obs_rv, obs_err;
    logic [2:0]  obs_rvc;
    logic [1:0]  obs_x, obs_y;
    logic [31:0] obs_data;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One clock cycle: compare DUT against the model, then advance the model at the edge.
    task automatic cyc();
        bit exp_ack;
        int g, vi;
        #1;
        vi = int'(i_vc);
        if (vi >= NUM_VC) exp_ack = i_v && !rst;
        else              exp_ack = i_v && !rst && (mq[vi].size() != DEPTH);
        chk("i_ack", 64'(i_ack), 64'(exp_ack));
        if (m_init) begin
            chk("r_v",    64'(r_v),    64'(m_rv));
            chk("r_vc",   64'(r_vc),   64'(m_rvc));
            chk("r_x",    64'(r_x),    64'(m_out.x));
            chk("r_y",    64'(r_y),    64'(m_out.y));
            chk("r_data", 64'(r_data), 64'(m_out.d));
            chk("err",    64'(err),    64'(m_err));
        end
        obs_ack = i_ack; obs_rv = r_v; obs_err = err; obs_rvc = r_vc;
        obs_x = r_x; obs_y = r_y; obs_data = r_data;
        if (r_v === 1'b1) begin
            rv_cnt++;
            seq.push_back(int'(r_vc));
        end
        @(posedge clk);
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                mq[v].delete();
                m_cred[v] = CREDITS;
            end
            m_rr = NUM_VC - 1; m_rv = 0; m_rvc = 0; m_out = '0; m_err = 0; m_init = 1;
        end else begin
            g = -1;
            for (int k = 1; k <= NUM_VC; k++)
                if (g < 0 && mq[(m_rr + k) % NUM_VC].size() > 0 && m_cred[(m_rr + k) % NUM_VC] > 0)
                    g = (m_rr + k) % NUM_VC;
            for (int v = 0; v < NUM_VC; v++)
                if (r_credit[v] && v != g) begin
                    if (m_cred[v] == CREDITS) m_err = 1;
                    else                      m_cred[v]++;
                end
            m_rv = (g >= 0);
            if (g >= 0) begin
                if (!r_credit[g]) m_cred[g]--;
                m_out = mq[g].pop_front();
                m_rvc = g;
                m_rr  = g;
            end
            if (exp_ack) begin
                if (vi >= NUM_VC) m_err = 1;
                else              mq[vi].push_back({i_x, i_y, i_data});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_v = 0; r_credit = '0;
        repeat (n) cyc();
    endtask

    task automatic send(input int vc, input logic [31:0] d);
        i_v = 1; i_vc = 3'(vc); i_x = 2'($urandom_range(0, 3)); i_y = 2'($urandom_range(0, 3));
        i_data = d; r_credit = '0;
        for (int t = 0; t < 40; t++) begin
            cyc();
            if (obs_ack) break;
        end
        if (!obs_ack) chk("send_timeout", 64'(obs_ack), 64'(1));
        i_v = 0;
    endtask

    task automatic do_reset();
        rst = 1; i_v = 0; r_credit = '0;
        cyc();
        rst = 0;
    endtask

    // Return all outstanding credits and drain all FIFOs.
    task automatic restore();
        bit done;
        i_v = 0;
        done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            for (int v = 0; v < NUM_VC; v++) r_credit[v] = (m_cred[v] < CREDITS);
            cyc();
            done = 1;
            for (int v = 0; v < NUM_VC; v++)
                if (mq[v].size() != 0 || m_cred[v] != CREDITS) done = 0;
        end
        chk("restore_done", 64'(done), 64'(1));
        idle(3);
    endtask

    initial begin
        int exp_seq [9];
        rst = 1; i_v = 0; i_vc = 0; i_x = 0; i_y = 0; i_data = 0; r_credit = '0;
        @(negedge clk);

        // Reset state; i_ack suppressed while rst is high
        i_v = 1; i_vc = 3'd1;
        cyc(); chk("ack_in_rst", 64'(obs_ack), 64'(0));
        cyc();
        rst = 0; i_v = 0;
        cyc();
        chk("rst_rv", 64'(obs_rv), 64'(0));
        chk("rst_err", 64'(obs_err), 64'(0));
        chk("rst_data", 64'(obs_data), 64'(0));

        // Single flit, 2-cycle latency
        i_v = 1; i_vc = 3'd1; i_x = 2'd2; i_y = 2'd3; i_data = 32'hDEADBEEF;
        cyc(); chk("t1_ack", 64'(obs_ack), 64'(1));
        i_v = 0;
        cyc(); chk("t1_rv_n1", 64'(obs_rv), 64'(0));
        cyc(); chk("t1_rv_n2", 64'(obs_rv), 64'(1));
        chk("t1_vc", 64'(obs_rvc), 64'(1));
        chk("t1_x", 64'(obs_x), 64'(2));
        chk("t1_y", 64'(obs_y), 64'(3));
        chk("t1_data", 64'(obs_data), 64'hDEADBEEF);
        chk("t1_cred", 64'(m_cred[1]), 64'(3));
        restore();

        // Credit exhaustion on VC0
        rv_cnt = 0;
        for (int i = 0; i < 6; i++) send(0, 32'h100 + 32'(i));
        idle(8);
        chk("t2_pulses", 64'(rv_cnt), 64'(4));
        chk("t2_count", 64'(mq[0].size()), 64'(2));
        r_credit = 4'b0001;
        cyc(); chk("t2_rv_p0", 64'(obs_rv), 64'(0));
        r_credit = '0;
        cyc(); chk("t2_rv_p1", 64'(obs_rv), 64'(0));
        cyc(); chk("t2_rv_p2", 64'(obs_rv), 64'(1));
        restore();

        // FIFO full on VC2 with credits exhausted
        for (int i = 0; i < 4; i++) send(2, $urandom);
        idle(6);
        for (int i = 0; i < 4; i++) send(2, $urandom);
        i_v = 1; i_vc = 3'd2; i_data = 32'h55AA55AA; r_credit = '0;
        repeat (3) begin
            cyc(); chk("t3_full_nack", 64'(obs_ack), 64'(0));
        end
        r_credit = 4'b0100;
        cyc(); chk("t3_nack_credit", 64'(obs_ack), 64'(0));
        r_credit = '0;
        cyc(); chk("t3_nack_pop", 64'(obs_ack), 64'(0));
        cyc(); chk("t3_ack_after", 64'(obs_ack), 64'(1));
        i_v = 0;
        restore();

        // Round-robin fairness across VC0, VC1, VC3
        do_reset();
        for (int i = 0; i < 4; i++) send(0, $urandom);
        for (int i = 0; i < 4; i++) send(1, $urandom);
        for (int i = 0; i < 4; i++) send(3, $urandom);
        idle(6);
        for (int i = 0; i < 3; i++) send(0, $urandom);
        for (int i = 0; i < 3; i++) send(1, $urandom);
        for (int i = 0; i < 3; i++) send(3, $urandom);
        idle(2);
        seq.delete();
        r_credit = 4'b1011;
        repeat (3) cyc();
        idle(12);
        exp_seq = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
        chk("t4_len", 64'(seq.size()), 64'(9));
        for (int i = 0; i < 9 && i < seq.size(); i++) chk("t4_rr", 64'(seq[i]), 64'(exp_seq[i]));
        restore();

        // Illegal VC, then credit overflow
        i_v = 1; i_vc = 3'd5; i_data = 32'hBAD0BAD0;
        cyc(); chk("t5_ack", 64'(obs_ack), 64'(1));
        i_v = 0;
        rv_cnt = 0;
        cyc(); chk("t5_err", 64'(obs_err), 64'(1));
        idle(3);
        chk("t5_no_rv", 64'(rv_cnt), 64'(0));
        do_reset();
        cyc(); chk("t5_err_clr", 64'(obs_err), 64'(0));
        r_credit = 4'b0001;
        cyc();
        r_credit = '0;
        cyc(); chk("t5_ovf_err", 64'(obs_err), 64'(1));
        chk("t5_cred", 64'(m_cred[0]), 64'(4));
        rv_cnt = 0;
        for (int i = 0; i < 5; i++) send(0, $urandom);
        idle(8);
        chk("t5_ovf_pulses", 64'(rv_cnt), 64'(4));
        restore();

        // Reset mid-traffic
        do_reset();
        for (int i = 0; i < 3; i++) send(1, $urandom);
        rst = 1;
        cyc();
        rst = 0;
        rv_cnt = 0;
        idle(6);
        chk("t6_no_rv", 64'(rv_cnt), 64'(0));
        chk("t6_cred", 64'(m_cred[1]), 64'(4));
        chk("t6_empty", 64'(mq[1].size()), 64'(0));
        i_v = 1; i_vc = 3'd1; i_x = 2'd1; i_y = 2'd0; i_data = 32'h12345678;
        cyc(); chk("t6_ack", 64'(obs_ack), 64'(1));
        i_v = 0;
        cyc(); chk("t6_rv_n1", 64'(obs_rv), 64'(0));
        cyc(); chk("t6_rv_n2", 64'(obs_rv), 64'(1));
        chk("t6_data", 64'(obs_data), 64'h12345678);

        // Randomized traffic
        do_reset();
        obs_ack = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (!(i_v && !obs_ack)) begin
                i_v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 63) == 0) i_vc = 3'($urandom_range(4, 7));
                else                            i_vc = 3'($urandom_range(0, NUM_VC - 1));
                i_x = 2'($urandom_range(0, 3));
                i_y = 2'($urandom_range(0, 3));
                i_data = $urandom;
            end
            for (int v = 0; v < NUM_VC; v++)
                r_credit[v] = (m_cred[v] < CREDITS) && ($urandom_range(0, 2) == 0);
            cyc();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
